imem_loader: RTL and testbench

- Write-side counterpart of the instruction ROM.
- Takes a byte stream from a host/debug link and packs it into 32-bit little-endian instruction words.
- Writes the words sequentially into instruction memory from address 0.
- Holds the core in flush/stall (core_hold) for the whole load, then releases it with a done pulse.

---
 rtl/imem_loader.sv | 111 +++++++++++
 tb/tb_imem_loader.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Packs a little-endian byte stream into 32-bit words and writes them to imem from address 0, holding the core meanwhile.
// Write strobe one cycle after a word's 4th byte (min 5 cycles/word); byte_ready is low outside RECV, and the source may stall indefinitely.
module imem_loader #(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              core_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    state_t            state;
    logic [1:0]        byte_idx;
    logic [23:0]       word;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   count;

    logic last_word;
    assign last_word = ({1'b0, addr} == (count - 1'b1));

    // Moore outputs are registered alongside the state transition that selects them.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            byte_idx   <= '0;
            word       <= '0;
            addr       <= '0;
            count      <= '0;
            byte_ready <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            core_hold  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (word_count == '0 || word_count > DEPTH_C) begin
                            err <= 1'b1;
                        end else begin
                            count      <= word_count;
                            addr       <= '0;
                            byte_idx   <= '0;
                            err        <= 1'b0;
                            state      <= RECV;
                            byte_ready <= 1'b1;
                            core_hold  <= 1'b1;
                            busy       <= 1'b1;
                        end
                    end
                end
                RECV: begin
                    if (byte_valid) begin
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: word[7:0]   <= byte_data;
                            2'd1: word[15:8]  <= byte_data;
                            2'd2: word[23:16] <= byte_data;
                            2'd3: begin
                                // The top byte goes straight into the output word.
                                wr_data    <= {byte_data, word};
                                wr_addr    <= addr;
                                wr_en      <= 1'b1;
                                byte_ready <= 1'b0;
                                state      <= WRITE;
                            end
                        endcase
                    end
                end
                WRITE: begin
                    wr_en <= 1'b0;
                    if (last_word) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        addr       <= addr + 1'b1;
                        byte_ready <= 1'b1;
                        state      <= RECV;
                    end
                end
                DONE: begin
                    done      <= 1'b0;
                    core_hold <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: inputs driven 1ns after posedge, writes logged on negedge.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [6:0]  word_count;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data;
    logic        core_hold;
    logic        busy;
    logic        done;
    logic        err;

    int total = 0;
    int bad   = 0;

    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];
    int          done_cnt = 0;
    int          rdy_in_write = 0;

    imem_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .word_count (word_count),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .core_hold  (core_hold),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en) begin
            log_addr.push_back({26'd0, wr_addr});
            log_data.push_back(wr_data);
            if (byte_ready) rdy_in_write++;
        end
        if (done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [6:0] n);
        start      = 1'b1;
        word_count = n;
        tick();
        start      = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        ok = 1'b0;
        byte_valid = 1'b0;
        repeat (gap) tick();
        byte_valid = 1'b1;
        byte_data  = b;
        for (int i = 0; i < 50; i++) begin
            if (byte_ready) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        byte_valid = 1'b0;
        if (!ok) chk("byte_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_seen", {31'd0, seen}, 32'd1);
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
    endtask

    logic [31:0] words3 [3] = '{32'h11223344, 32'hDEADBEEF, 32'h00C0FFEE};
    int          seq_err;
    int          dc0;

    initial begin
        rst = 1'b1; start = 1'b0; word_count = '0; byte_valid = 1'b0; byte_data = '0;
        tick(); tick();
        chk("rst_outs", {24'd0, byte_ready, wr_en, core_hold, busy, done, err, 2'b00}, 32'd0);
        chk("rst_addr_data", {26'd0, wr_addr} | wr_data, 32'd0);
        rst = 1'b0;
        tick();

        // single word back-to-back
        clear_log();
        do_start(7'd1);
        chk("t1_hold_after_start", {30'd0, core_hold, busy}, 32'd3);
        send_byte(8'h13, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        chk("t1_wr_en", {31'd0, wr_en}, 32'd1);
        chk("t1_wr_addr", {26'd0, wr_addr}, 32'd0);
        chk("t1_wr_data", wr_data, 32'h00000013);
        chk("t1_rdy_write", {31'd0, byte_ready}, 32'd0);
        tick();
        chk("t1_done_hold", {29'd0, done, core_hold, wr_en}, 32'd6);
        tick();
        chk("t1_idle", {29'd0, done, core_hold, busy}, 32'd0);
        chk("t1_wr_data_held", wr_data, 32'h00000013);
        chk("t1_nwrites", log_addr.size(), 32'd1);

        // three words with gaps
        clear_log();
        dc0 = done_cnt;
        do_start(7'd3);
        for (int w = 0; w < 3; w++) send_word(words3[w], 2);
        wait_done();
        chk("t2_nwrites", log_addr.size(), 32'd3);
        for (int w = 0; w < 3 && w < log_addr.size(); w++) begin
            chk($sformatf("t2_addr%0d", w), log_addr[w], w);
            chk($sformatf("t2_data%0d", w), log_data[w], words3[w]);
        end
        chk("t2_rdy_in_write", rdy_in_write, 32'd0);
        tick();
        chk("t2_done_once", done_cnt - dc0, 32'd1);

        // invalid counts then a good load
        clear_log();
        do_start(7'd0);
        chk("t3_err0", {30'd0, err, busy}, 32'd2);
        tick();
        do_start(7'd65);
        chk("t3_err65", {30'd0, err, busy}, 32'd2);
        tick(); tick();
        chk("t3_no_write", log_addr.size(), 32'd0);
        do_start(7'd2);
        chk("t3_err_cleared", {30'd0, err, busy}, 32'd1);
        send_word(32'hA5A5_0001, 0);
        send_word(32'h0102_0304, 1);
        wait_done();
        chk("t3_nwrites", log_addr.size(), 32'd2);
        if (log_data.size() == 2) chk("t3_data1", log_data[1], 32'h0102_0304);

        // full memory
        clear_log();
        tick();
        dc0 = done_cnt;
        do_start(7'd64);
        for (int w = 0; w < 64; w++) send_word(w, 0);
        wait_done();
        repeat (5) tick();
        chk("t4_nwrites", log_addr.size(), 32'd64);
        seq_err = 0;
        for (int w = 0; w < log_addr.size(); w++)
            if (log_addr[w] != w || log_data[w] != w) seq_err++;
        chk("t4_seq", seq_err, 32'd0);
        chk("t4_last_addr", {26'd0, wr_addr}, 32'd63);
        chk("t4_last_data", wr_data, 32'h0000003F);
        chk("t4_done_once", done_cnt - dc0, 32'd1);

        // reset mid-load
        clear_log();
        dc0 = done_cnt;
        do_start(7'd4);
        send_word(32'hCAFE_0000, 0);
        send_word(32'hCAFE_0001, 0);
        send_byte(8'h77, 0); send_byte(8'h66, 0);
        rst = 1'b1;
        tick();
        chk("t5_outs_zero", {24'd0, byte_ready, wr_en, core_hold, busy, done, err, 2'b00}, 32'd0);
        chk("t5_addr_data_zero", {26'd0, wr_addr} | wr_data, 32'd0);
        rst = 1'b0;
        repeat (10) tick();
        chk("t5_nwrites", log_addr.size(), 32'd2);
        chk("t5_no_done", done_cnt - dc0, 32'd0);

        // start while busy
        clear_log();
        dc0 = done_cnt;
        do_start(7'd3);
        send_byte(8'h01, 0); send_byte(8'h02, 0);
        do_start(7'd1);
        send_byte(8'h03, 0); send_byte(8'h04, 0);
        send_word(32'h5555_AAAA, 0);
        send_word(32'h0F0F_F0F0, 0);
        wait_done();
        chk("t6_nwrites", log_addr.size(), 32'd3);
        if (log_data.size() == 3) begin
            chk("t6_data0", log_data[0], 32'h04030201);
            chk("t6_addr2", log_addr[2], 32'd2);
        end
        chk("t6_no_err", {31'd0, err}, 32'd0);
        tick();
        chk("t6_done_once", done_cnt - dc0, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
